shift_sequencer: RTL and testbench

- Multi-cycle right-shift controller: accepts an operand and a shift amount, then applies a 1-bit right-shift step once per clock until the shift amount is consumed.
- Returns the result through a valid/ready handshake.
- Provides logical and arithmetic modes. Sits beside the ALU as the variable-amount shift unit, reusing the single-bit shift datapath instead of a barrel shifter.

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_step.sv | 12 +
 rtl/shift_sequencer.sv | 86 ++++++++
 tb/tb_shift_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle right-shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Single-bit right shift with caller-supplied fill bit entering at the MSB.
module shift_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = {i_fill, i_data[WIDTH-1:1]};

endmodule

// File: rtl/shift_sequencer.sv
// Variable-amount right shifter that iterates a 1-bit step once per clock,
// returning the result over a valid/ready handshake.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    state_e             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_count;
    logic               r_mode;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_fill;
    logic [WIDTH-1:0]   w_shifted;

    assign w_fill = (r_mode == SHIFT_ARITH) ? r_data[WIDTH-1] : 1'b0;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data (r_data),
        .i_fill (w_fill),
        .o_data (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_count    <= '0;
            r_mode     <= SHIFT_LOGICAL;
            r_op_count <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_count <= in_shamt;
                        r_mode  <= in_arith;
                        r_state <= (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_data  <= w_shifted;
                    r_count <= r_count - 1'b1;
                    // The step taken while count==1 is the last one.
                    if (r_count == SHAMT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state    <= ST_IDLE;
                        r_op_count <= r_op_count + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs come only from registers or state decode; no input-to-output path.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_data;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed scoreboard bench for shift_sequencer; CNT_W=2 exposes counter wrap.
module tb_shift_sequencer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CNT_W   = 2;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_arith;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               busy;
    logic [CNT_W-1:0]   op_count;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               lat_q[$];

    shift_sequencer #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                               input logic [SHAMT_W-1:0] sh,
                                               input logic ar);
        if (ar) return WIDTH'($signed(d) >>> sh);
        return d >> sh;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Accept edge is the posedge inside this task; returns #1 after it.
    task automatic accept(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] sh,
                          input logic ar);
        int n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_arith = ar;
        @(posedge clk); #1;
        // Scramble inputs after the acceptance edge; they must not matter.
        in_valid = 1'b0;
        in_data  = ~d;
        in_shamt = ~sh;
        in_arith = ~ar;
        exp_q.push_back(model(d, sh, ar));
        lat_q.push_back(int'(sh));
    endtask

    // Latency is counted in clock edges after the acceptance edge.
    task automatic wait_result(input string tag);
        int n = 0;
        int lat;
        logic [WIDTH-1:0] e;
        while (out_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        lat = lat_q.pop_front();
        e   = exp_q.pop_front();
        check({tag, "_latency"}, n, lat);
        check({tag, "_data"}, out_data, e);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        check({tag, "_opcount"}, {30'd0, op_count}, model_cnt);
        check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] rd;
        logic             seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_op_count", {30'd0, op_count}, 32'd0);

        accept(32'hF000_0000, 5'd4, 1'b0);
        check("shift_busy", {30'd0, busy, in_ready}, 32'b10);
        wait_result("log4");
        handshake("log4");

        accept(32'h8000_0010, 5'd4, 1'b1);
        wait_result("ari4");
        handshake("ari4");
        accept(32'h8000_0010, 5'd4, 1'b0);
        wait_result("log4b");
        handshake("log4b");

        accept(32'h1234_5678, 5'd0, 1'b1);
        wait_result("sh0");
        handshake("sh0");
        accept(32'h8000_0000, 5'd31, 1'b1);
        wait_result("ari31");
        handshake("ari31");
        accept(32'h8000_0000, 5'd31, 1'b0);
        wait_result("log31");
        handshake("log31");

        // Backpressure with a competing request held throughout DONE.
        accept(32'hC3A5_0F96, 5'd3, 1'b1);
        wait_result("bp");
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_FF00;
            in_shamt = 5'd8;
            in_arith = 1'b0;
            @(posedge clk); #1;
            check("bp_hold", {29'd0, out_valid, in_ready, busy}, 32'b101);
            check("bp_data", out_data, held);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        check("bp_release_opcount", {30'd0, op_count}, model_cnt);
        check("bp_no_bypass", {29'd0, in_ready, out_valid, busy}, 32'b100);
        accept(32'h0000_FF00, 5'd8, 1'b0);
        wait_result("bp2");
        handshake("bp2");

        // Reset two cycles into a long shift discards the operation.
        accept(32'hDEAD_BEEF, 5'd8, 1'b1);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_cnt = 0;
        check("mid_rst_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
        check("mid_rst_opcount", {30'd0, op_count}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("mid_rst_no_result", {31'd0, seen}, 32'd0);

        // Five deliveries walk the 2-bit counter through 1,2,3,0,1.
        for (int i = 0; i < 5; i++) begin
            rd = $urandom;
            accept(rd, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            wait_result("wrap");
            handshake("wrap");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
